pipe_ctrl_tracker: RTL and testbench
====================================

Name: pipe_ctrl_tracker

Overview:
- Receiver end of the decode control bundle. Takes ex/mem/wb control vectors and register fields from instruction decode.
- Carries them through the ID/EX, EX/MEM and MEM/WB control registers and unpacks them into per-stage strobes.
- Owns load-use hazard stalls, branch-taken flushes and (optionally) forwarding selects.
- Sits between the decode stage and the execute, memory and writeback datapaths of the 5-stage MIPS pipeline.

Parameters:
- ADDR_W, 5, register-file address width.
- ZERO_REG, 0, hard-wired zero register index; never a hazard or forwarding source.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_ex_ctrl  in  4  {reg_dst, alu_op[1:0], alu_src}.
- id_mem_ctrl  in  3  {branch, mem_read, mem_write}.
- id_wb_ctrl  in  2  {reg_write, mem_to_reg}.
- id_rs  in  ADDR_W  source register 1 of the decoding instruction.
- id_rt  in  ADDR_W  source register 2 / load destination.
- id_rd  in  ADDR_W  R-type destination.
- mem_zero  in  1  ALU zero flag registered in EX/MEM.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID clear.
- pc_src  out  1  select branch target.
- ex_reg_dst, ex_alu_src  out  1 each  EX-stage strobes.
- ex_alu_op  out  2  EX-stage ALU op.
- ex_dest  out  ADDR_W  resolved EX destination.
- mem_branch, mem_read, mem_write  out  1 each  MEM-stage strobes.
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage strobes.
- wb_dest  out  ADDR_W  writeback register index.
- forward_a, forward_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

Behaviour:
- Reset: the asynchronous rst_n low clears all stage registers (control, rs, rt, rd, dest) to 0. All strobes are 0, forward_* = 00, pc_src = 0, if_id_flush = 0, pc_write = 1, if_id_write = 1. Reset mid-operation discards in-flight control immediately, without waiting for a clock edge.
- Pipeline latency: one clk per stage.
  - ID/EX loads {id ctrl, id_rs, id_rt, id_rd} when id_valid; otherwise it loads a zero bubble.
  - ex_dest = ex_reg_dst ? ex_rd : ex_rt, combinational.
  - EX/MEM loads EX mem/wb ctrl and ex_dest.
  - MEM/WB loads MEM wb ctrl and dest.
  - Net effect: an instruction's wb strobes appear 3 cycles after its ID cycle.
- Load-use stall (combinational), all of these must hold:
  - id_valid;
  - ID/EX mem_read;
  - ex_rt != ZERO_REG;
  - ex_rt == id_rs or ex_rt == id_rt.
  - Effect: pc_write = 0, if_id_write = 0, ID/EX loads a bubble. EX/MEM and MEM/WB still advance.
- Branch flush: pc_src = mem_branch & mem_zero.
  - When pc_src = 1: if_id_flush = 1. At the next edge, ID/EX and EX/MEM control load zero while MEM/WB advances normally.
- Stall and flush in the same cycle: flush wins. pc_write = 1, if_id_write = 1, no stall.
- Bubbles are all-zero control vectors, so they never write memory or the register file.
- Back-to-back stall conditions re-evaluate every cycle. A stall lasts exactly 1 cycle per load-use pair.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - forward_a (against ex_rs) / forward_b (against ex_rt) = 10 if EX/MEM reg_write, EX/MEM dest != ZERO_REG and EX/MEM dest matches.
  - Else 01 if the same conditions hold for MEM/WB.
  - Else 00. EX/MEM has priority.
  - Stalls only on load-use.
- Undefined:
  - forward_* tied to 00.
  - Stall is extended to any RAW hazard: id_rs or id_rt equal to a nonzero ex_dest with ID/EX reg_write, or to the EX/MEM dest with EX/MEM reg_write.
  - The register file is write-before-read, so the WB stage is not checked.

Test Plan:
- Reset pulse mid-stream with a live lw in EX → same cycle: all strobes 0, pc_write = 1, if_id_write = 1, wb_reg_write = 0.
- R-type: ex = 4'b1100, wb = 2'b10, rd = 3, issued in cycle 0 → cycle 1: ex_reg_dst = 1, ex_alu_op = 10, ex_dest = 3; cycle 3: wb_reg_write = 1, wb_dest = 3.
- lw rt = 5 (mem = 3'b010, wb = 2'b11) then add with rs = 5 → one cycle of pc_write = 0 / if_id_write = 0 and a bubble in EX. With FORWARDING_EN, the add later sees forward_a = 01.
- Same as above but add uses rs = 0 with lw rt = 0 → no stall.
- beq (mem = 3'b100) with mem_zero = 1 in MEM → pc_src = 1, if_id_flush = 1; next cycle EX and MEM strobes all 0. Inject a simultaneous load-use condition → no stall, pc_write = 1.
- FORWARDING_EN: EX/MEM and MEM/WB both writing dest 7, ex_rs = 7, ex_rt = 7 → forward_a = forward_b = 10. Without the macro, the add issued behind a writer of 7 stalls until the writer leaves EX/MEM, and forward_* stays 00.

Source files
------------

// File: rtl/pipe_ctrl_tracker.sv
// pipe_ctrl_tracker: ID/EX -> EX/MEM -> MEM/WB control pipeline with load-use stall and branch flush.
// Build option FORWARDING_EN: drive forwarding selects; otherwise stall on every RAW hazard.
module pipe_ctrl_tracker #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_ex_ctrl,
    input  logic [2:0]        id_mem_ctrl,
    input  logic [1:0]        id_wb_ctrl,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              mem_zero,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              pc_src,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic [ADDR_W-1:0] ex_dest,
    output logic              mem_branch,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [3:0]        r_ex_ctrl;
    logic [2:0]        r_ex_mem;
    logic [1:0]        r_ex_wb;
    logic [ADDR_W-1:0] r_ex_rt;
    logic [ADDR_W-1:0] r_ex_rd;
    logic [2:0]        r_mem_ctrl;
    logic [1:0]        r_mem_wb;
    logic [ADDR_W-1:0] r_mem_dest;
    logic [1:0]        r_wb_ctrl;
    logic [ADDR_W-1:0] r_wb_dest;
    logic              w_load_use;
    logic              w_hazard;
    logic              w_stall;
    logic              w_flush;
    logic              w_ex_load;

    assign ex_reg_dst    = r_ex_ctrl[3];
    assign ex_alu_op     = r_ex_ctrl[2:1];
    assign ex_alu_src    = r_ex_ctrl[0];
    assign ex_dest       = ex_reg_dst ? r_ex_rd : r_ex_rt;
    assign mem_branch    = r_mem_ctrl[2];
    assign mem_read      = r_mem_ctrl[1];
    assign mem_write     = r_mem_ctrl[0];
    assign wb_reg_write  = r_wb_ctrl[1];
    assign wb_mem_to_reg = r_wb_ctrl[0];
    assign wb_dest       = r_wb_dest;

    assign w_flush     = r_mem_ctrl[2] & mem_zero;
    assign pc_src      = w_flush;
    assign if_id_flush = w_flush;
    assign w_load_use  = id_valid & r_ex_mem[1] & (r_ex_rt != ZR) & (r_ex_rt == id_rs | r_ex_rt == id_rt);

`ifdef FORWARDING_EN
    logic [ADDR_W-1:0] r_ex_rs;

    assign w_hazard  = w_load_use;
    assign forward_a = (r_mem_wb[1] && r_mem_dest != ZR && r_mem_dest == r_ex_rs) ? 2'b10 :
                       (r_wb_ctrl[1] && r_wb_dest != ZR && r_wb_dest == r_ex_rs) ? 2'b01 : 2'b00;
    assign forward_b = (r_mem_wb[1] && r_mem_dest != ZR && r_mem_dest == r_ex_rt) ? 2'b10 :
                       (r_wb_ctrl[1] && r_wb_dest != ZR && r_wb_dest == r_ex_rt) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ex_rs <= '0;
        else
            r_ex_rs <= w_ex_load ? id_rs : '0;
    end
`else
    logic w_ex_raw;
    logic w_mem_raw;

    // write-before-read regfile: only EX and MEM producers can be too early
    assign w_ex_raw  = r_ex_wb[1] & (ex_dest != ZR) & (ex_dest == id_rs | ex_dest == id_rt);
    assign w_mem_raw = r_mem_wb[1] & (r_mem_dest != ZR) & (r_mem_dest == id_rs | r_mem_dest == id_rt);
    assign w_hazard  = w_load_use | (id_valid & (w_ex_raw | w_mem_raw));
    assign forward_a = 2'b00;
    assign forward_b = 2'b00;
`endif

    assign w_stall     = w_hazard & ~w_flush;
    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;
    assign w_ex_load   = id_valid & ~w_stall & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl  <= '0;
            r_ex_mem   <= '0;
            r_ex_wb    <= '0;
            r_ex_rt    <= '0;
            r_ex_rd    <= '0;
            r_mem_ctrl <= '0;
            r_mem_wb   <= '0;
            r_mem_dest <= '0;
            r_wb_ctrl  <= '0;
            r_wb_dest  <= '0;
        end else begin
            r_ex_ctrl  <= w_ex_load ? id_ex_ctrl : '0;
            r_ex_mem   <= w_ex_load ? id_mem_ctrl : '0;
            r_ex_wb    <= w_ex_load ? id_wb_ctrl : '0;
            r_ex_rt    <= w_ex_load ? id_rt : '0;
            r_ex_rd    <= w_ex_load ? id_rd : '0;
            r_mem_ctrl <= w_flush ? '0 : r_ex_mem;
            r_mem_wb   <= w_flush ? '0 : r_ex_wb;
            r_mem_dest <= w_flush ? '0 : ex_dest;
            r_wb_ctrl  <= r_mem_wb;
            r_wb_dest  <= r_mem_dest;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// tb_pipe_ctrl_tracker: directed vector tables, async-reset sequence and randomized model comparison.
module tb_pipe_ctrl_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_ex_ctrl = '0;
    logic [2:0] id_mem_ctrl = '0;
    logic [1:0] id_wb_ctrl = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       mem_zero = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, pc_src;
    logic       ex_reg_dst, ex_alu_src, mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [1:0] ex_alu_op, forward_a, forward_b;
    logic [4:0] ex_dest, wb_dest;
    int         checks = 0;
    int         failures = 0;

    pipe_ctrl_tracker #(.ADDR_W(5), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
        .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .mem_zero(mem_zero), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .pc_src(pc_src), .ex_reg_dst(ex_reg_dst),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_dest(ex_dest),
        .mem_branch(mem_branch), .mem_read(mem_read), .mem_write(mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         start;
        logic       v;
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        logic [4:0] rs, rt, rd;
        logic       mz;
        logic       pcw, fl;
        logic [3:0] exs;
        logic [4:0] exd;
        logic [2:0] mems;
        logic [1:0] wbs;
        logic [4:0] wbd;
        logic [1:0] fa, fb;
    } vec_t;

    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        logic [4:0] rs, rt, dest;
    } stg_t;

    vec_t vq[$];
    stg_t st[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit s, input logic v, input logic [3:0] ex, input logic [2:0] mem,
                       input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic mz, input logic pcw, input logic fl,
                       input logic [3:0] exs, input logic [4:0] exd, input logic [2:0] mems,
                       input logic [1:0] wbs, input logic [4:0] wbd, input logic [1:0] fa,
                       input logic [1:0] fb);
        vec_t t;
        t = '{s, v, ex, mem, wb, rs, rt, rd, mz, pcw, fl, exs, exd, mems, wbs, wbd, fa, fb};
        vq.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [3:0] ex, input logic [2:0] mem,
                         input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic mz);
        id_valid = v; id_ex_ctrl = ex; id_mem_ctrl = mem; id_wb_ctrl = wb;
        id_rs = rs; id_rt = rt; id_rd = rd; mem_zero = mz;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit writes(input stg_t s, input logic [4:0] a, input logic [4:0] b);
        return s.wb[1] && s.dest != 0 && (s.dest == a || s.dest == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
`ifdef FORWARDING_EN
        if (writes(st[1], r, r)) return 2'b10;
        if (writes(st[2], r, r)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    initial begin
        // R-type through all stages
        add(1,1,4'b1100,3'b000,2'b10,1,2,3,0, 1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b1100,3,3'b000,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b10,3,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        // lw r5 then add using r5
        add(1,1,4'b0001,3'b010,2'b11,1,5,0,0, 1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,1,4'b1100,3'b000,2'b10,5,6,7,0, 0,0,4'b0001,5,3'b000,2'b00,0,0,0);
`ifdef FORWARDING_EN
        add(0,1,4'b1100,3'b000,2'b10,5,6,7,0, 1,0,4'b0000,0,3'b010,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b1100,7,3'b000,2'b11,5,2'b01,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b00,0,0,0);
`else
        add(0,1,4'b1100,3'b000,2'b10,5,6,7,0, 0,0,4'b0000,0,3'b010,2'b00,0,0,0);
        add(0,1,4'b1100,3'b000,2'b10,5,6,7,0, 1,0,4'b0000,0,3'b000,2'b11,5,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b1100,7,3'b000,2'b00,0,0,0);
`endif
        // lw r0 then add using r0: never a hazard
        add(1,1,4'b0001,3'b010,2'b11,1,0,0,0, 1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,1,4'b1100,3'b000,2'b10,0,6,7,0, 1,0,4'b0001,0,3'b000,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b1100,7,3'b010,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b11,0,0,0);
        // taken beq flushes, overriding a simultaneous load-use
        add(1,1,4'b0010,3'b100,2'b00,1,2,0,0, 1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,1,4'b0001,3'b010,2'b11,0,4,0,0, 1,0,4'b0010,2,3'b000,2'b00,0,0,0);
        add(0,1,4'b1100,3'b000,2'b10,4,0,8,1, 1,1,4'b0001,4,3'b100,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        // two writers of r7 ahead of a reader of r7
        add(1,1,4'b1100,3'b000,2'b10,1,2,7,0, 1,0,4'b0000,0,3'b000,2'b00,0,0,0);
        add(0,1,4'b1100,3'b000,2'b10,3,4,7,0, 1,0,4'b1100,7,3'b000,2'b00,0,0,0);
`ifdef FORWARDING_EN
        add(0,1,4'b1100,3'b000,2'b10,7,7,9,0, 1,0,4'b1100,7,3'b000,2'b00,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b1100,9,3'b000,2'b10,7,2'b10,2'b10);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b0000,0,3'b000,2'b10,7,0,0);
`else
        add(0,1,4'b1100,3'b000,2'b10,7,7,9,0, 0,0,4'b1100,7,3'b000,2'b00,0,0,0);
        add(0,1,4'b1100,3'b000,2'b10,7,7,9,0, 0,0,4'b0000,0,3'b000,2'b10,7,0,0);
        add(0,1,4'b1100,3'b000,2'b10,7,7,9,0, 1,0,4'b0000,0,3'b000,2'b10,7,0,0);
        add(0,0,0,0,0,0,0,0,0,                1,0,4'b1100,9,3'b000,2'b00,0,0,0);
`endif

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            vec_t t;
            t = vq[i];
            if (t.start) pulse_reset();
            drive(t.v, t.ex, t.mem, t.wb, t.rs, t.rt, t.rd, t.mz);
            #1;
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(t.pcw));
            chk($sformatf("v%0d_if_id_write", i), 32'(if_id_write), 32'(t.pcw));
            chk($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(t.fl));
            chk($sformatf("v%0d_if_id_flush", i), 32'(if_id_flush), 32'(t.fl));
            chk($sformatf("v%0d_ex_strobes", i), 32'({ex_reg_dst, ex_alu_op, ex_alu_src}), 32'(t.exs));
            chk($sformatf("v%0d_ex_dest", i), 32'(ex_dest), 32'(t.exd));
            chk($sformatf("v%0d_mem_strobes", i), 32'({mem_branch, mem_read, mem_write}), 32'(t.mems));
            chk($sformatf("v%0d_wb_strobes", i), 32'({wb_reg_write, wb_mem_to_reg}), 32'(t.wbs));
            if (t.wbs[1]) chk($sformatf("v%0d_wb_dest", i), 32'(wb_dest), 32'(t.wbd));
            chk($sformatf("v%0d_forward_a", i), 32'(forward_a), 32'(t.fa));
            chk($sformatf("v%0d_forward_b", i), 32'(forward_b), 32'(t.fb));
            @(negedge clk);
        end

        // asynchronous reset with a live lw in EX and a stall pending
        pulse_reset();
        drive(1, 4'b0001, 3'b010, 2'b11, 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 4'b0001, 3'b010, 2'b11, 0, 2, 0, 0);
        @(negedge clk);
        drive(1, 4'b0001, 3'b010, 2'b11, 0, 3, 0, 0);
        @(negedge clk);
        drive(1, 4'b1100, 3'b000, 2'b10, 3, 0, 9, 0);
        #1;
        chk("pre_rst_pc_write", 32'(pc_write), 32'(0));
        chk("pre_rst_wb_reg_write", 32'(wb_reg_write), 32'(1));
        chk("pre_rst_mem_read", 32'(mem_read), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_pc_write", 32'(pc_write), 32'(1));
        chk("rst_if_id_write", 32'(if_id_write), 32'(1));
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'(0));
        chk("rst_mem_read", 32'(mem_read), 32'(0));
        chk("rst_ex_strobes", 32'({ex_reg_dst, ex_alu_op, ex_alu_src}), 32'(0));
        chk("rst_ex_dest", 32'(ex_dest), 32'(0));
        chk("rst_flush", 32'({pc_src, if_id_flush}), 32'(0));
        chk("rst_forward", 32'({forward_a, forward_b}), 32'(0));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // randomized run against a stage-array model
        pulse_reset();
        for (int k = 0; k < 3; k++) st[k] = '0;
        for (int c = 0; c < 600; c++) begin
            stg_t n;
            logic v, mz, ld_use, need, flush, stall;
            logic [4:0] rd;
            logic [31:0] exp_v, act_v;
            v = ($urandom_range(0, 4) != 0);
            n.ex = 4'($urandom);
            n.mem = {($urandom_range(0, 5) == 0), 2'($urandom)};
            n.wb = 2'($urandom);
            n.rs = 5'($urandom_range(0, 3));
            n.rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            mz = 1'($urandom);
            n.dest = n.ex[3] ? rd : n.rt;
            drive(v, n.ex, n.mem, n.wb, n.rs, n.rt, rd, mz);
            ld_use = v && st[0].mem[1] && st[0].rt != 0 && (st[0].rt == n.rs || st[0].rt == n.rt);
`ifdef FORWARDING_EN
            need = ld_use;
`else
            need = ld_use || (v && (writes(st[0], n.rs, n.rt) || writes(st[1], n.rs, n.rt)));
`endif
            flush = st[1].mem[2] && mz;
            stall = need && !flush;
            #1;
            exp_v = {5'b0, !stall, !stall, flush, flush, st[0].ex, st[0].dest, st[1].mem, st[2].wb,
                     (st[2].wb[1] ? st[2].dest : 5'd0), fwd_sel(st[0].rs), fwd_sel(st[0].rt)};
            act_v = {5'b0, pc_write, if_id_write, pc_src, if_id_flush,
                     ex_reg_dst, ex_alu_op, ex_alu_src, ex_dest, mem_branch, mem_read, mem_write,
                     wb_reg_write, wb_mem_to_reg, (st[2].wb[1] ? wb_dest : 5'd0), forward_a, forward_b};
            chk($sformatf("rand_c%0d", c), act_v, exp_v);
            st[2] = st[1];
            st[1] = flush ? '0 : st[0];
            st[0] = (v && !stall && !flush) ? n : '0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
